// File: rtl/ysyx_23060025_ifu_prefetch_if.sv
// Bundles the redirect, IDU-side handshake and icache read port of the prefetching IFU.
// The master modport is the IFU's view; the slave modport is its environment's view.
interface ysyx_23060025_ifu_prefetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  redirect_valid_i;
    logic [ADDR_WIDTH-1:0] redirect_pc_i;
    logic                  ifu_valid_o;
    logic                  idu_ready_i;
    logic [DATA_WIDTH-1:0] if_inst_o;
    logic [ADDR_WIDTH-1:0] if_pc_o;
    logic                  halted_o;
    logic                  out_psel;
    logic [ADDR_WIDTH-1:0] out_paddr;
    logic                  out_pready;
    logic [DATA_WIDTH-1:0] out_prdata;

    modport master (
        input  redirect_valid_i, redirect_pc_i, idu_ready_i, out_pready, out_prdata,
        output ifu_valid_o, if_inst_o, if_pc_o, halted_o, out_psel, out_paddr
    );

    modport slave (
        output redirect_valid_i, redirect_pc_i, idu_ready_i, out_pready, out_prdata,
        input  ifu_valid_o, if_inst_o, if_pc_o, halted_o, out_psel, out_paddr
    );
endinterface

// File: rtl/ysyx_23060025_ifu_prefetch.sv
// Sequential prefetch IFU: single-outstanding reads feed a first-word-fall-through {pc, inst}
// queue towards the IDU; redirect flushes everything and ebreak stops further fetching.
module ysyx_23060025_ifu_prefetch #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h8000_0000,
    parameter logic [DATA_WIDTH-1:0] EBREAK_INST = 32'h0010_0073
) (
    input logic clock,
    input logic rstn,
    ysyx_23060025_ifu_prefetch_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_HALT} state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] fetch_pc_nx;
    logic [ADDR_WIDTH-1:0] drain_addr;
    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nx;
    logic                  redirect;
    logic                  resp;
    logic                  push;
    logic                  pop;

    assign redirect = bus.redirect_valid_i;
    assign resp     = bus.out_pready;
    assign push     = (state == S_REQ) && resp && !redirect;
    assign pop      = (count != '0) && bus.idu_ready_i && !redirect;

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        count_nx    = count;
        if (redirect) begin
            count_nx    = '0;
            fetch_pc_nx = bus.redirect_pc_i;
        end else begin
            count_nx = count + CNT_W'(push) - CNT_W'(pop);
            if (push) fetch_pc_nx = fetch_pc + ADDR_WIDTH'(4);
        end
        case (state)
            S_IDLE:  if (redirect || count < DEPTH_C) state_nx = S_REQ;
            S_REQ: begin
                // An un-answered request must still complete, so a redirect parks us in S_DRAIN.
                if (redirect) begin
                    state_nx = resp ? S_REQ : S_DRAIN;
                end else if (resp) begin
                    if (bus.out_prdata == EBREAK_INST) state_nx = S_HALT;
                    else if (count_nx < DEPTH_C)       state_nx = S_REQ;
                    else                               state_nx = S_IDLE;
                end
            end
            S_DRAIN: if (resp) state_nx = S_REQ;
            S_HALT:  if (redirect) state_nx = S_REQ;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            count    <= count_nx;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // The bus address must stay put while draining even though fetch_pc already moved on.
            if (state == S_REQ && state_nx == S_DRAIN) drain_addr <= fetch_pc;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= bus.out_prdata;
        end
    end

    assign bus.out_psel    = (state == S_REQ) || (state == S_DRAIN);
    assign bus.out_paddr   = (state == S_DRAIN) ? drain_addr : fetch_pc;
    assign bus.ifu_valid_o = (count != '0);
    assign bus.if_pc_o     = pc_mem[rd_ptr];
    assign bus.if_inst_o   = inst_mem[rd_ptr];
    assign bus.halted_o    = (state == S_HALT);
endmodule
